// File: rtl/instr_loader.sv
// instr_loader: write-side companion to the instruction memory.
// Accepts decoded instruction triples (op, r1, r2) over a valid/ready
// handshake, packs each one into a 9-bit word {op, r1, r2}, and writes
// the words to consecutive memory addresses starting at a programmable base.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   start      one-cycle load request, honoured only in IDLE
//   base_addr  first write address, sampled on accepted start
//   count      number of words to load (0..2**PC_BITS), sampled on accepted start
//   in_valid   source presents a triple
//   in_ready   loader accepts a triple this cycle (high in LOAD)
//   in_op/in_r1/in_r2  instruction fields
//   wr_en/wr_addr/wr_data  registered memory write port (one cycle after accept)
//   busy       high from accepted start through the done cycle (stalls fetch)
//   done       one-cycle completion pulse, coincides with the final write
//   wrap_err   sticky: write address wrapped with words still remaining
//   checksum   (INSTR_LOADER_CHECKSUM_EN only) running XOR of words written
//
// Optional feature macro: INSTR_LOADER_CHECKSUM_EN
module instr_loader #(
  parameter int PC_BITS   = 12,
  parameter int WORD_BITS = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [PC_BITS-1:0]   base_addr,
  input  logic [PC_BITS:0]     count,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_op,
  input  logic [2:0]           in_r1,
  input  logic [2:0]           in_r2,
  output logic                 wr_en,
  output logic [PC_BITS-1:0]   wr_addr,
  output logic [WORD_BITS-1:0] wr_data,
  output logic                 busy,
  output logic                 done,
  output logic                 wrap_err
`ifdef INSTR_LOADER_CHECKSUM_EN
  ,
  output logic [WORD_BITS-1:0] checksum
`endif
);

  if (WORD_BITS != 9) begin : g_bad_word_bits
    $error("instr_loader: WORD_BITS must be 9 (3+3+3)");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_t;

  state_t                 state_q, state_d;
  logic [PC_BITS-1:0]     addr_q, addr_d;
  logic [PC_BITS:0]       rem_q, rem_d;
  logic                   wr_en_q, wr_en_d;
  logic [PC_BITS-1:0]     wr_addr_q, wr_addr_d;
  logic [WORD_BITS-1:0]   wr_data_q, wr_data_d;
  logic                   wrap_q, wrap_d;
  logic [WORD_BITS-1:0]   word;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [WORD_BITS-1:0]   cks_q, cks_d;
`endif

  assign word = {in_op, in_r1, in_r2};

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wrap_d    = wrap_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
    cks_d     = cks_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          rem_d   = count;
          wrap_d  = 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
          cks_d   = '0;
`endif
          state_d = (count != '0) ? ST_LOAD : ST_DONE;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = word;
          addr_d    = addr_q + PC_BITS'(1);
          rem_d     = rem_q - (PC_BITS+1)'(1);
          // Wrapping on the last word is a legitimate full-memory fill,
          // so the flag needs words still pending after this one.
          if (addr_q == '1 && rem_q != (PC_BITS+1)'(1)) wrap_d = 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
          cks_d     = cks_q ^ word;
`endif
          if (rem_q == (PC_BITS+1)'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wrap_q    <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      cks_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wrap_q    <= wrap_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
      cks_q     <= cks_d;
`endif
    end
  end

  assign in_ready = (state_q == ST_LOAD);
  assign done     = (state_q == ST_DONE);
  // busy rises combinationally with the accepted start so fetch stalls
  // in the very cycle the load is requested.
  assign busy     = (state_q == ST_IDLE) ? start : 1'b1;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign wrap_err = wrap_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
  assign checksum = cks_q;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: stimulus pushes expected writes,
// a negedge monitor pops and compares each presented write.
module tb_instr_loader;
  localparam int PC_BITS = 12;
  localparam int WB      = 9;

  logic              clk = 1'b0;
  logic              reset, start, in_valid;
  logic [PC_BITS-1:0] base_addr;
  logic [PC_BITS:0]   count;
  logic [2:0]        in_op, in_r1, in_r2;
  logic              in_ready, wr_en, busy, done, wrap_err;
  logic [PC_BITS-1:0] wr_addr;
  logic [WB-1:0]     wr_data;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [WB-1:0]     checksum;
`endif

  instr_loader #(.PC_BITS(PC_BITS), .WORD_BITS(WB)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .count(count), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_r1(in_r1), .in_r2(in_r2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .wrap_err(wrap_err)
`ifdef INSTR_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PC_BITS-1:0] a;
    logic [WB-1:0]      d;
    logic               last;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   busy_cyc, done_cyc, ready_cyc, wr_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (busy)     busy_cyc++;
    if (done)     done_cyc++;
    if (in_ready) ready_cyc++;
    if (wr_en) begin
      wr_cyc++;
      if (q.size() == 0) begin
        chk("unexpected_write", 32'(wr_addr), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.a));
        chk("wr_data", 32'(wr_data), 32'(e.d));
        chk("done_with_write", 32'(done), 32'(e.last));
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    busy_cyc = 0; done_cyc = 0; ready_cyc = 0; wr_cyc = 0;
  endtask

  task automatic do_start(input int b, input int c);
    start = 1'b1; base_addr = PC_BITS'(b); count = (PC_BITS+1)'(c);
    cyc();
    start = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input logic [2:0] r1, input logic [2:0] r2);
    in_valid = 1'b1; in_op = op; in_r1 = r1; in_r2 = r2;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic expect_w(input int a, input logic [WB-1:0] d, input logic last);
    exp_t e;
    e.a = PC_BITS'(a); e.d = d; e.last = last;
    q.push_back(e);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_wr_en"},    32'(wr_en), 0);
    chk({tag, "_wr_addr"},  32'(wr_addr), 0);
    chk({tag, "_wr_data"},  32'(wr_data), 0);
    chk({tag, "_busy"},     32'(busy), 0);
    chk({tag, "_done"},     32'(done), 0);
    chk({tag, "_wrap_err"}, 32'(wrap_err), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    base_addr = '0; count = '0; in_op = '0; in_r1 = '0; in_r2 = '0;
    cyc(); cyc();
    reset = 1'b0;
    chk_idle_zero("reset");

    // Basic load: three back-to-back triples from address 0.
    clr();
    do_start(0, 3);
    expect_w(0, 9'b001010011, 1'b0);
    expect_w(1, 9'b111000101, 1'b0);
    expect_w(2, 9'b000000000, 1'b1);
    send(3'd1, 3'd2, 3'd3);
    send(3'd7, 3'd0, 3'd5);
    send(3'd0, 3'd0, 3'd0);
    chk("basic_done_now", 32'(done), 1);
`ifdef INSTR_LOADER_CHECKSUM_EN
    chk("basic_checksum", 32'(checksum), 32'(9'b110010110));
`endif
    cyc(); cyc();
    chk("basic_busy_cycles", 32'(busy_cyc), 5);
    chk("basic_done_cycles", 32'(done_cyc), 1);
    chk("basic_writes", 32'(wr_cyc), 3);

    // Gapped source: valid 1,0,0,1.
    clr();
    do_start(100, 2);
    expect_w(100, {3'd4, 3'd5, 3'd6}, 1'b0);
    expect_w(101, {3'd2, 3'd2, 3'd1}, 1'b1);
    send(3'd4, 3'd5, 3'd6);
    cyc(); cyc();
    send(3'd2, 3'd2, 3'd1);
    chk("gap_done_after_accept", 32'(done), 1);
    cyc(); cyc();
    chk("gap_writes", 32'(wr_cyc), 2);
    chk("gap_busy_cycles", 32'(busy_cyc), 6);

    // Zero count: straight to DONE, nothing accepted or written.
    clr();
    in_valid = 1'b1;
    do_start(5, 0);
    chk("zero_done_next_cycle", 32'(done), 1);
    cyc();
    chk("zero_done_one_cycle", 32'(done), 0);
    cyc(); cyc();
    in_valid = 1'b0;
    chk("zero_writes", 32'(wr_cyc), 0);
    chk("zero_ready", 32'(ready_cyc), 0);
    chk("zero_busy_cycles", 32'(busy_cyc), 2);
    chk("zero_done_cycles", 32'(done_cyc), 1);

    // Wrap: 4094, 4095, 0, 1.
    clr();
    do_start(4094, 4);
    expect_w(4094, 9'd11, 1'b0);
    expect_w(4095, 9'd22, 1'b0);
    expect_w(0,    9'd33, 1'b0);
    expect_w(1,    9'd44, 1'b1);
    send(3'd0, 3'd1, 3'd3);
    chk("wrap_before", 32'(wrap_err), 0);
    send(3'd0, 3'd2, 3'd6);
    chk("wrap_set", 32'(wrap_err), 1);
    send(3'd0, 3'd4, 3'd1);
    send(3'd0, 3'd5, 3'd4);
    chk("wrap_hold_done", 32'(wrap_err), 1);
    cyc(); cyc();
    chk("wrap_hold_idle", 32'(wrap_err), 1);
    do_start(10, 1);
    chk("wrap_cleared_by_start", 32'(wrap_err), 0);
    expect_w(10, 9'd7, 1'b1);
    send(3'd0, 3'd0, 3'd7);
    cyc(); cyc();

    // Ignored start mid-load, then reset on the accept of word 3.
    clr();
    do_start(200, 5);
    expect_w(200, 9'd1, 1'b0);
    expect_w(201, 9'd2, 1'b0);
    expect_w(202, 9'd3, 1'b0);
    send(3'd0, 3'd0, 3'd1);
    send(3'd0, 3'd0, 3'd2);
    start = 1'b1; base_addr = PC_BITS'(999); count = (PC_BITS+1)'(1);
    send(3'd0, 3'd0, 3'd3);
    start = 1'b0;
    chk("ign_still_loading", 32'(in_ready), 1);
    reset = 1'b1;
    send(3'd0, 3'd0, 3'd4);
    reset = 1'b0;
    chk_idle_zero("midreset");
    cyc(); cyc();
    chk("midreset_writes", 32'(wr_cyc), 3);
    do_start(50, 1);
    expect_w(50, 9'd5, 1'b1);
    send(3'd0, 3'd0, 3'd5);
    cyc(); cyc();

    // Full-memory fill from a nonzero base: last write at base-1, wrap flagged.
    clr();
    do_start(4, 4096);
    for (int i = 0; i < 4096; i++) begin
      logic [WB-1:0] w;
      w = WB'(i * 37);
      expect_w((4 + i) % 4096, w, (i == 4095));
      send(w[8:6], w[5:3], w[2:0]);
    end
    chk("full_base4_wrap", 32'(wrap_err), 1);
    cyc(); cyc();
    chk("full_base4_writes", 32'(wr_cyc), 4096);

    // Full-memory fill from base 0: wrap only on the final word, no flag.
    clr();
    do_start(0, 4096);
    for (int i = 0; i < 4096; i++) begin
      logic [WB-1:0] w;
      w = WB'(i);
      expect_w(i, w, (i == 4095));
      send(w[8:6], w[5:3], w[2:0]);
    end
    chk("full_base0_nowrap", 32'(wrap_err), 0);
    cyc(); cyc();
    chk("full_base0_writes", 32'(wr_cyc), 4096);

    chk("scoreboard_drained", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
